mbscore_ifetch_buf: RTL and testbench

Parametrised instruction-fetch unit with a prefetch buffer for the MBScore pipeline.
- Issues sequential fetches to instruction memory over a req/ack handshake and queues {pc, instruction} pairs in a DEPTH-entry FIFO.
- Presents the head entry to decode, which pops it with `next`.
- Taken jumps/branches (`redirect`) flush the buffer and restart fetch. `hlt` freezes fetching.

---
 rtl/mbscore_ifetch_buf_pkg.sv | 18 +
 rtl/mbscore_ifetch_buf_fifo.sv | 58 +++++
 rtl/mbscore_ifetch_buf.sv | 124 ++++++++++++
 tb/tb_mbscore_ifetch_buf.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbscore_ifetch_buf_pkg.sv
// Shared constants and fetch-FSM encoding for the MBScore instruction-fetch buffer.
// Both the top level and the prefetch FIFO import this package.
package mbscore_ifetch_buf_pkg;

    localparam int          DEFAULT_DATA_WIDTH = 32;
    localparam int          DEFAULT_ADDR_WIDTH = 32;
    localparam int          DEFAULT_DEPTH      = 4;
    localparam int          DEFAULT_PC_STEP    = 4;
    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_REQ  = 2'd1,
        F_DROP = 2'd2,
        F_HALT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/mbscore_ifetch_buf_fifo.sv
// Synchronous prefetch FIFO with flush. Full/empty come from the occupancy counter,
// and the head entry is read combinationally (forced to zero while empty).
module mbscore_ifetch_fifo
    import mbscore_ifetch_buf_pkg::*;
#(
    parameter int WIDTH = DEFAULT_ADDR_WIDTH + DEFAULT_DATA_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic                   o_valid,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // Flush wins over everything; a push into a full buffer is only legal alongside a pop.
    assign w_pop  = i_pop && (r_count != '0) && !i_flush;
    assign w_push = i_push && !i_flush && ((r_count != CW'(DEPTH)) || w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_valid = (r_count != '0);
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/mbscore_ifetch_buf.sv
// MBScore instruction-fetch unit: sequential req/ack fetcher feeding a prefetch FIFO,
// with redirect flush/refetch and a level halt.
module mbscore_ifetch_buf
    import mbscore_ifetch_buf_pkg::*;
#(
    parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int                    DEPTH      = DEFAULT_DEPTH,
    parameter int                    PC_STEP    = DEFAULT_PC_STEP,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    output logic                    o_mem_re,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    input  logic                    i_mem_ack,
    input  logic [DATA_WIDTH-1:0]   i_inst_in,
    input  logic                    i_next,
    output logic                    o_inst_valid,
    output logic [DATA_WIDTH-1:0]   o_inst_out,
    output logic [ADDR_WIDTH-1:0]   o_pc_out,
    input  logic                    i_redirect,
    input  logic [ADDR_WIDTH-1:0]   i_redirect_addr,
    input  logic                    i_hlt,
    output logic                    o_halted,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    fetch_state_e          r_state;
    fetch_state_e          w_state_next;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [ADDR_WIDTH-1:0] w_pc_next;
    logic                  w_load_addr;
    logic                  w_push;
    logic                  w_pop;
    logic [CW-1:0]         w_count;
    logic [CW-1:0]         w_count_after;
    logic [EW-1:0]         w_head;

    assign o_mem_re = (r_state == F_REQ) || (r_state == F_DROP);
    assign w_push   = (r_state == F_REQ) && i_mem_ack && !i_redirect;
    assign w_pop    = i_next && o_inst_valid && !i_redirect;

    // Occupancy the buffer will hold after this edge; decides whether another fetch fits.
    assign w_count_after = i_redirect ? '0 : (w_count + CW'(w_push) - CW'(w_pop));
    assign w_pc_next     = i_redirect ? i_redirect_addr :
                           (w_push ? (r_fetch_pc + ADDR_WIDTH'(PC_STEP)) : r_fetch_pc);

    always_comb begin
        w_state_next = r_state;
        w_load_addr  = 1'b0;
        case (r_state)
            F_IDLE: begin
                if (i_hlt) begin
                    w_state_next = F_HALT;
                end else if (w_count_after < CW'(DEPTH)) begin
                    w_state_next = F_REQ;
                    w_load_addr  = 1'b1;
                end
            end
            F_REQ: begin
                if (i_mem_ack) begin
                    if (i_redirect) begin
                        w_state_next = F_IDLE;
                    end else if (i_hlt) begin
                        w_state_next = F_HALT;
                    end else if (w_count_after < CW'(DEPTH)) begin
                        w_load_addr = 1'b1;
                    end else begin
                        w_state_next = F_IDLE;
                    end
                end else if (i_redirect) begin
                    w_state_next = F_DROP;
                end
            end
            F_DROP: begin
                if (i_mem_ack) w_state_next = F_IDLE;
            end
            F_HALT: begin
                if (!i_hlt) w_state_next = F_IDLE;
            end
            default: w_state_next = F_IDLE;
        endcase
    end

    // The request address only moves when a new request is launched, never mid-handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= F_IDLE;
            r_fetch_pc <= RESET_PC;
            r_mem_addr <= RESET_PC;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_pc_next;
            if (w_load_addr) r_mem_addr <= w_pc_next;
        end
    end

    mbscore_ifetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_redirect),
        .i_push  (w_push),
        .i_data  ({r_fetch_pc, i_inst_in}),
        .i_pop   (w_pop),
        .o_valid (o_inst_valid),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign o_mem_addr = r_mem_addr;
    assign o_pc_out   = w_head[EW-1:DATA_WIDTH];
    assign o_inst_out = w_head[DATA_WIDTH-1:0];
    assign o_halted   = (r_state == F_HALT);
    assign o_count    = w_count;

endmodule

// File: tb/tb_mbscore_ifetch_buf.sv
// Self-checking bench for mbscore_ifetch_buf: directed scenarios plus a random phase,
// checked against a queue-based transaction model and a bench-side memory.
module tb_mbscore_ifetch_buf;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entryT;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        o_mem_re;
    logic [31:0] o_mem_addr;
    logic        i_mem_ack;
    logic [31:0] i_inst_in;
    logic        i_next;
    logic        o_inst_valid;
    logic [31:0] o_inst_out;
    logic [31:0] o_pc_out;
    logic        i_redirect;
    logic [31:0] i_redirect_addr;
    logic        i_hlt;
    logic        o_halted;
    logic [2:0]  o_count;

    int          compared = 0;
    int          mismatched = 0;
    entryT       q[$];
    logic [31:0] ackLog[$];
    logic [31:0] modelPc;
    logic        dropping;
    int          reqCycles;
    int          ackLat;
    logic [31:0] heldAddr;
    logic        lastAck;
    logic [31:0] lastAckAddr;

    mbscore_ifetch_buf #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .DEPTH      (DEPTH),
        .PC_STEP    (4),
        .RESET_PC   (32'h0)
    ) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .o_mem_re        (o_mem_re),
        .o_mem_addr      (o_mem_addr),
        .i_mem_ack       (i_mem_ack),
        .i_inst_in       (i_inst_in),
        .i_next          (i_next),
        .o_inst_valid    (o_inst_valid),
        .o_inst_out      (o_inst_out),
        .o_pc_out        (o_pc_out),
        .i_redirect      (i_redirect),
        .i_redirect_addr (i_redirect_addr),
        .i_hlt           (i_hlt),
        .o_halted        (o_halted),
        .o_count         (o_count)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return 32'h1000_0000 | addr;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkState();
        checkOutput("count", 64'(o_count), 64'(q.size()));
        checkOutput("inst_valid", 64'(o_inst_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            checkOutput("head_pc", 64'(o_pc_out), 64'(q[0].pc));
            checkOutput("head_inst", 64'(o_inst_out), 64'(q[0].inst));
        end else begin
            checkOutput("empty_pc_zero", 64'(o_pc_out), 64'(0));
            checkOutput("empty_inst_zero", 64'(o_inst_out), 64'(0));
        end
    endtask

    task automatic modelReset();
        q.delete();
        modelPc   = 32'h0;
        dropping  = 1'b0;
        reqCycles = 0;
    endtask

    // Transaction-level prediction of what the coming clock edge does to the buffer.
    task automatic modelStep(input logic ackNow);
        if (i_redirect) begin
            q.delete();
            modelPc  = i_redirect_addr;
            dropping = o_mem_re && !ackNow;
        end else begin
            if (i_next && q.size() != 0) void'(q.pop_front());
            if (ackNow) begin
                if (dropping) begin
                    dropping = 1'b0;
                end else begin
                    checkOutput("fetch_addr", 64'(o_mem_addr), 64'(modelPc));
                    q.push_back('{pc: modelPc, inst: memWord(modelPc)});
                    ackLog.push_back(modelPc);
                    modelPc = modelPc + 32'd4;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic nxt, input logic redir, input logic [31:0] raddr,
                                 input logic halt);
        logic ackNow;
        i_next          = nxt;
        i_redirect      = redir;
        i_redirect_addr = raddr;
        i_hlt           = halt;
        ackNow          = o_mem_re && (reqCycles >= ackLat);
        i_mem_ack       = ackNow;
        i_inst_in       = memWord(o_mem_addr);
        if (o_mem_re && reqCycles > 0) checkOutput("addr_hold", 64'(o_mem_addr), 64'(heldAddr));
        heldAddr    = o_mem_addr;
        lastAck     = ackNow;
        lastAckAddr = o_mem_addr;
        modelStep(ackNow);
        if (o_mem_re && !ackNow) reqCycles++;
        else reqCycles = 0;
        @(posedge i_clk);
        @(negedge i_clk);
        i_mem_ack  = 1'b0;
        i_redirect = 1'b0;
        checkState();
    endtask

    initial begin
        int n;
        logic [31:0] resumePc;
        i_rst_n = 1'b0; i_next = 1'b0; i_redirect = 1'b0; i_redirect_addr = '0;
        i_hlt = 1'b0; i_mem_ack = 1'b0; i_inst_in = '0;
        ackLat = 1;
        heldAddr = '0; lastAck = 1'b0; lastAckAddr = '0;
        modelReset();
        repeat (2) @(negedge i_clk);
        checkOutput("rst_mem_re", 64'(o_mem_re), 64'(0));
        checkOutput("rst_mem_addr", 64'(o_mem_addr), 64'(0));
        checkOutput("rst_halted", 64'(o_halted), 64'(0));
        checkState();
        i_rst_n = 1'b1;

        // Cold fill with decode stalled.
        repeat (12) applyStimulus(1'b0, 1'b0, '0, 1'b0);
        checkOutput("fill_mem_re", 64'(o_mem_re), 64'(0));
        checkOutput("fill_count", 64'(o_count), 64'(4));
        checkOutput("fill_inst", 64'(o_inst_out), 64'h1000_0000);
        checkOutput("fill_pc", 64'(o_pc_out), 64'(0));
        checkOutput("fill_nreq", 64'(ackLog.size()), 64'(4));
        for (int i = 0; i < 4; i++) checkOutput("fill_req_addr", 64'(ackLog[i]), 64'(i * 4));

        // Streaming.
        repeat (24) applyStimulus(1'b1, 1'b0, '0, 1'b0);

        // Redirect while a slow request is outstanding.
        ackLat = 3;
        n = 0;
        while (!(o_mem_re && reqCycles == 0) && n < 40) begin
            applyStimulus(1'b1, 1'b0, '0, 1'b0);
            n++;
        end
        checkOutput("wait_req_start", 64'(o_mem_re), 64'(1));
        resumePc = o_mem_addr;
        applyStimulus(1'b0, 1'b1, 32'h100, 1'b0);
        checkOutput("drop_mem_re", 64'(o_mem_re), 64'(1));
        checkOutput("drop_mem_addr", 64'(o_mem_addr), 64'(resumePc));
        n = 0;
        while (!o_inst_valid && n < 40) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0);
            n++;
        end
        checkOutput("redir_pc", 64'(o_pc_out), 64'h100);
        checkOutput("redir_inst", 64'(o_inst_out), 64'h1000_0100);

        // Redirect, ack and pop on the same edge with two entries buffered.
        ackLat = 1;
        n = 0;
        while (!(o_count == 3'd2 && o_mem_re && reqCycles >= ackLat) && n < 40) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0);
            n++;
        end
        checkOutput("simul_setup_count", 64'(o_count), 64'(2));
        applyStimulus(1'b1, 1'b1, 32'h200, 1'b0);
        checkOutput("simul_count", 64'(o_count), 64'(0));
        checkOutput("simul_valid", 64'(o_inst_valid), 64'(0));
        n = 0;
        while (!o_inst_valid && n < 40) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0);
            n++;
        end
        checkOutput("simul_pc", 64'(o_pc_out), 64'h200);

        // Halt in the middle of a request.
        ackLat = 2;
        n = 0;
        while (!(o_mem_re && reqCycles == 0) && n < 40) begin
            applyStimulus(1'b1, 1'b0, '0, 1'b0);
            n++;
        end
        checkOutput("halt_req_start", 64'(o_mem_re), 64'(1));
        n = 0;
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        while (!lastAck && n < 40) begin
            applyStimulus(1'b1, 1'b0, '0, 1'b1);
            n++;
        end
        resumePc = lastAckAddr + 32'd4;
        checkOutput("halt_halted", 64'(o_halted), 64'(1));
        checkOutput("halt_mem_re", 64'(o_mem_re), 64'(0));
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, '0, 1'b1);
            checkOutput("halt_hold_re", 64'(o_mem_re), 64'(0));
            checkOutput("halt_hold_halted", 64'(o_halted), 64'(1));
        end
        n = 0;
        while (!o_mem_re && n < 40) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0);
            n++;
        end
        checkOutput("resume_addr", 64'(o_mem_addr), 64'(resumePc));

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if (reqCycles == 0) ackLat = $urandom_range(0, 3);
            applyStimulus($urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
                          $urandom & 32'hFFFF_FFFC, $urandom_range(0, 9) == 0);
        end

        // Address wrap, then asynchronous reset mid-request.
        ackLat = 1;
        ackLog.delete();
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        n = 0;
        while (ackLog.size() < 2 && n < 40) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0);
            n++;
        end
        checkOutput("wrap_nreq", 64'(ackLog.size()), 64'(2));
        checkOutput("wrap_first", 64'(ackLog[0]), 64'hFFFF_FFFC);
        checkOutput("wrap_second", 64'(ackLog[1]), 64'h0);
        n = 0;
        while (!o_mem_re && n < 40) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0);
            n++;
        end
        checkOutput("prereset_mem_re", 64'(o_mem_re), 64'(1));
        #2 i_rst_n = 1'b0;
        #1;
        checkOutput("async_rst_mem_re", 64'(o_mem_re), 64'(0));
        checkOutput("async_rst_count", 64'(o_count), 64'(0));
        checkOutput("async_rst_valid", 64'(o_inst_valid), 64'(0));
        modelReset();
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        checkOutput("post_rst_addr", 64'(o_mem_addr), 64'(0));
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        checkOutput("post_rst_first_req", 64'(o_mem_addr), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
